// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame constants and the
// receiver-side scan codes / device responses.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam int PS2_FRAME_EDGES        = 10;
  localparam int DEFAULT_INHIBIT_CYCLES = 5000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  // Scan codes and device responses seen by the receiver path
  localparam logic [7:0] PS2_SC_EXTENDED  = 8'hE0;
  localparam logic [7:0] PS2_SC_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status handshake between a command issuer and ps2_host_tx.
interface ps2_host_tx_if;
  logic       iStart;
  logic [7:0] iData;
  logic       oBusy;
  logic       oDone;
  logic       oAckErr;
  logic       oError;

  modport master (output iStart, iData, input oBusy, oDone, oAckErr, oError);
  modport slave  (input iStart, iData, output oBusy, oDone, oAckErr, oError);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad, with a falling-edge strobe.
module ps2_line_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic async_i,
  output logic level_o,
  output logic fe_o
);

  logic meta_q, sync_q, prev_q;

  // Reset to the idle (released) line level so no edge is seen after reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fe_o    = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocks
// out 8 data bits + odd parity + stop on device clock falls, checks the ack.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             Clock,
  input  logic             Reset,
  ps2_host_tx_if.slave     bus,
  input  logic             PS2_CLK_IN,
  input  logic             PS2_DATA_IN,
  output logic             oPS2_CLK_OE,
  output logic             oPS2_DATA_OE
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             clk_s, clk_fe, data_s, data_fe;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       frame_q;
  logic             clk_oe_q, data_oe_q, busy_q, done_q, ackerr_q, error_q;
  logic             accept, bus_idle, step, watched, tmo_hit;

  ps2_line_sync u_clk_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .async_i (PS2_CLK_IN),
    .level_o (clk_s),
    .fe_o    (clk_fe)
  );

  ps2_line_sync u_data_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .async_i (PS2_DATA_IN),
    .level_o (data_s),
    .fe_o    (data_fe)
  );

  // A request landing on the done/error cycle is dropped; requester retries
  assign accept    = (state_q == ST_IDLE) & bus.iStart & ~done_q & ~error_q;
  assign bus_idle  = clk_s & data_s & ~data_fe;
  assign step      = (state_q == ST_WAIT_IDLE) ? bus_idle : clk_fe;
  assign watched   = (state_q == ST_SEND) | (state_q == ST_ACK) | (state_q == ST_WAIT_IDLE);
  assign tmo_hit   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign bit_cnt_d = bit_cnt_q + 4'd1;

  // Frame bits in wire order: data LSB first, parity, stop
  always_ff @(posedge Clock) begin
    if (accept) frame_q <= {1'b1, odd_parity(bus.iData), bus.iData};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ackerr_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (watched && !step && tmo_hit) begin
        state_q   <= ST_IDLE;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        error_q   <= 1'b0 | 1'b1;
        cnt_q     <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (accept) begin
              state_q   <= ST_INHIBIT;
              cnt_q     <= '0;
              bit_cnt_q <= '0;
              ackerr_q  <= 1'b0;
              busy_q    <= 1'b1;
              clk_oe_q  <= 1'b1;
              data_oe_q <= 1'b0;
            end
          end
          ST_INHIBIT: begin
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
              state_q   <= ST_RTS;
              cnt_q     <= '0;
              data_oe_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_RTS: begin
            state_q  <= ST_SEND;
            clk_oe_q <= 1'b0;
            cnt_q    <= '0;
          end
          ST_SEND: begin
            if (clk_fe) begin
              cnt_q     <= '0;
              bit_cnt_q <= bit_cnt_d;
              data_oe_q <= ~frame_q[bit_cnt_q];
              if (bit_cnt_q == 4'(PS2_FRAME_EDGES - 1)) state_q <= ST_ACK;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_ACK: begin
            if (clk_fe) begin
              ackerr_q <= data_s;
              state_q  <= ST_WAIT_IDLE;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_WAIT_IDLE: begin
            if (bus_idle) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oPS2_CLK_OE  = clk_oe_q;
  assign oPS2_DATA_OE = data_oe_q;
  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oAckErr  = ackerr_q;
  assign bus.oError   = error_q;

endmodule
